// File: rtl/monitor_loader.sv
// Byte-stream loader: parses ADR/CNT/DATA frames and writes each word to the monitor RAM over Wishbone.
// Optional trailing XOR checksum byte is compiled in with MONITOR_LOADER_CHECKSUM_EN.
module monitor_loader (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_stb,
  output logic        rx_ack,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic        wb_we_o,
  input  logic        wb_ack_i,
  output logic        write_lock,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_ADR = 3'd0,
    S_CNT = 3'd1,
    S_DAT = 3'd2,
    S_WB  = 3'd3,
`ifdef MONITOR_LOADER_CHECKSUM_EN
    S_SUM = 3'd4,
`endif
    S_END = 3'd5
  } state_t;

  state_t      state_q, state_d, tail_st;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_new;
  logic        stb_q, done_q;
  logic        accept;

  // Rx handshake: a byte moves when rx_stb and rx_ack are both high on a clock edge.
  assign rx_ack  = (state_q == S_ADR) || (state_q == S_CNT) || (state_q == S_DAT)
`ifdef MONITOR_LOADER_CHECKSUM_EN
                   || (state_q == S_SUM)
`endif
                   ;
  assign accept  = rx_stb & rx_ack;
  assign cnt_new = {cnt_q[7:0], rx_data};

`ifdef MONITOR_LOADER_CHECKSUM_EN
  assign tail_st = S_SUM;
`else
  assign tail_st = S_END;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_ADR: if (accept) begin
        adr_d = {adr_q[23:0], rx_data};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = S_CNT;
          idx_d   = 2'd0;
        end
      end
      S_CNT: if (accept) begin
        cnt_d = cnt_new;
        idx_d = idx_q + 2'd1;
        if (idx_q[0]) begin
          idx_d   = 2'd0;
          state_d = (cnt_new == 16'd0) ? tail_st : S_DAT;
        end
      end
      S_DAT: if (accept) begin
        dat_d = {dat_q[23:0], rx_data};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = S_WB;
          idx_d   = 2'd0;
        end
      end
      S_WB: if (wb_ack_i) begin
        adr_d   = adr_q + 32'd4;
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? tail_st : S_DAT;
      end
`ifdef MONITOR_LOADER_CHECKSUM_EN
      S_SUM: if (accept) state_d = S_END;
`endif
      S_END:   state_d = S_ADR;
      default: state_d = S_ADR;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_ADR;
      idx_q   <= 2'd0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      cnt_q   <= 16'd0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      stb_q   <= (state_d == S_WB);
      done_q  <= (state_d == S_END);
    end
  end

`ifdef MONITOR_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;

  // The first ADR byte restarts the running XOR and clears the previous frame's error.
  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (accept) begin
      if (state_q == S_ADR && idx_q == 2'd0) begin
        sum_d = rx_data;
        err_d = 1'b0;
      end else if (state_q == S_SUM) begin
        err_d = err_q | (rx_data != sum_q);
      end else begin
        sum_d = sum_q ^ rx_data;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sum_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign wb_adr_o   = {adr_q[31:2], 2'b00};
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = 4'hF;
  assign wb_stb_o   = stb_q;
  assign wb_cyc_o   = stb_q;
  assign wb_we_o    = 1'b1;
  assign write_lock = !((state_q == S_DAT) || (state_q == S_WB));
  assign busy       = (state_q != S_ADR) || (idx_q != 2'd0);
  assign done       = done_q;

endmodule

// File: tb/tb_monitor_loader.sv
// Directed bench for monitor_loader: byte driver, Wishbone slave with programmable ack delay,
// and a write scoreboard fed when frames are sent.
module tb_monitor_loader;
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  rx_data;
  logic        rx_stb;
  logic        rx_ack;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o, wb_cyc_o, wb_we_o, wb_ack_i;
  logic        write_lock, busy, done, error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int low_cycles = 1;
  int last_acc = 0;
  int word_gap = 0;
  logic [63:0] exp_q[$];
  logic [31:0] words[$];

  monitor_loader dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_stb(rx_stb), .rx_ack(rx_ack),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i), .write_lock(write_lock),
    .busy(busy), .done(done), .error(error)
  );

  // Clock / cycle counter
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Driver: hold the byte until the DUT takes it, remember the accepting cycle.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b;
    rx_stb  = 1'b1;
    while (!rx_ack && n < 100) begin
      tick();
      n++;
    end
    chk("rx_ack_wait", 32'(n < 100), 32'd1);
    tick();
    last_acc = cyc;
    rx_stb   = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] adr, input bit bad_sum);
    logic [7:0]  sum;
    logic [31:0] a;
    logic [15:0] cnt;
    int          prev_last;
    cnt = 16'(words.size());
    a   = {adr[31:2], 2'b00};
    foreach (words[w]) begin
      exp_q.push_back({a, words[w]});
      a = a + 32'd4;
    end
    sum = 8'd0;
    prev_last = 0;
    for (int i = 3; i >= 0; i--) begin
      send_byte(adr[8*i +: 8]);
      sum ^= adr[8*i +: 8];
      if (i == 3) chk("error_cleared", 32'(error), 32'd0);
    end
    send_byte(cnt[15:8]);
    send_byte(cnt[7:0]);
    sum ^= cnt[15:8] ^ cnt[7:0];
    if (cnt != 16'd0) chk("lock_in_data", 32'(write_lock), 32'd0);
    foreach (words[w]) begin
      for (int i = 3; i >= 0; i--) begin
        send_byte(words[w][8*i +: 8]);
        sum ^= words[w][8*i +: 8];
        if (i == 3 && w > 0) word_gap = last_acc - prev_last;
      end
      prev_last = last_acc;
      chk("stb_rise", 32'(wb_stb_o), 32'd1);
    end
`ifdef MONITOR_LOADER_CHECKSUM_EN
    send_byte(bad_sum ? ~sum : sum);
`else
    if (bad_sum) sum = ~sum;
`endif
  endtask

  task automatic wait_done(input logic exp_err);
    int n;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(n < 200), 32'd1);
    chk("error_at_done", 32'(error), 32'(exp_err));
    chk("lock_at_done", 32'(write_lock), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("rx_ack_after_done", 32'(rx_ack), 32'd1);
    chk("all_writes_seen", 32'(exp_q.size() == 0), 32'd1);
  endtask

  // Wishbone slave: ack comes low_cycles cycles after the request appears; scoreboard pop on ack.
  initial begin : wb_slave
    int          scnt;
    logic [31:0] cap_adr, cap_dat;
    logic [63:0] e;
    scnt = 0;
    wb_ack_i = 1'b0;
    forever begin
      tick();
      if (wb_stb_o && !wb_ack_i) begin
        if (scnt == 0) begin
          cap_adr = wb_adr_o;
          cap_dat = wb_dat_o;
          chk("wb_cyc_eq_stb", 32'(wb_cyc_o), 32'd1);
          chk("wb_sel", 32'(wb_sel_o), 32'hF);
          chk("wb_we", 32'(wb_we_o), 32'd1);
          chk("lock_in_write", 32'(write_lock), 32'd0);
        end else begin
          chk("adr_stable", wb_adr_o, cap_adr);
          chk("dat_stable", wb_dat_o, cap_dat);
          chk("cyc_stable", 32'(wb_cyc_o), 32'd1);
        end
        chk("rx_ack_in_write", 32'(rx_ack), 32'd0);
        if (scnt >= low_cycles) begin
          wb_ack_i = 1'b1;
          scnt = 0;
          chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_adr", wb_adr_o, e[63:32]);
            chk("wb_dat", wb_dat_o, e[31:0]);
          end
        end else begin
          scnt++;
        end
      end else begin
        wb_ack_i = 1'b0;
        scnt = 0;
      end
    end
  end

  initial begin : main
    logic [7:0] rb [10];
    rb = '{8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    sys_rst = 1'b1;
    rx_stb  = 1'b0;
    rx_data = 8'h00;
    tick();
    tick();
    sys_rst = 1'b0;

    chk("rst_rx_ack", 32'(rx_ack), 32'd1);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_lock", 32'(write_lock), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    // Two-word load, 1-cycle ack: next byte accepted 3 cycles after the last data byte.
    words = '{32'hDEADBEEF, 32'h01234567};
    send_frame(32'h0000_0800, 1'b0);
    chk("word_gap_fast", 32'(word_gap), 32'd3);
    wait_done(1'b0);

    // Empty frame: no bus activity, lock stays set.
    words = '{};
    send_frame(32'h0000_0100, 1'b0);
    chk("cnt0_no_stb", 32'(wb_stb_o), 32'd0);
    chk("cnt0_lock", 32'(write_lock), 32'd1);
    wait_done(1'b0);

    // Address wrap at the top of the 32-bit space.
    words = '{32'hA5A5A5A5, 32'h5A5A5A5A};
    send_frame(32'hFFFF_FFFC, 1'b0);
    wait_done(1'b0);

    // Low address bits are ignored.
    words = '{32'hCAFEF00D};
    send_frame(32'h0000_0403, 1'b0);
    wait_done(1'b0);

    // Slave stall: ack held low for 5 cycles.
    low_cycles = 5;
    words = '{32'h11111111, 32'h22222222};
    send_frame(32'h0000_1000, 1'b0);
    chk("word_gap_stall", 32'(word_gap), 32'd7);
    wait_done(1'b0);
    low_cycles = 1;

    // Reset during an outstanding write.
    low_cycles = 100;
    for (int i = 0; i < 10; i++) send_byte(rb[i]);
    chk("pre_rst_stb", 32'(wb_stb_o), 32'd1);
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("mid_rst_stb", 32'(wb_stb_o), 32'd0);
    chk("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("mid_rst_lock", 32'(write_lock), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rx_ack", 32'(rx_ack), 32'd1);
    low_cycles = 1;
    tick();
    words = '{32'h0BADCAFE};
    send_frame(32'h0000_2000, 1'b0);
    wait_done(1'b0);

`ifdef MONITOR_LOADER_CHECKSUM_EN
    words = '{32'h12345678};
    send_frame(32'h0000_3000, 1'b0);
    wait_done(1'b0);
    words = '{32'h9ABCDEF0};
    send_frame(32'h0000_3004, 1'b1);
    wait_done(1'b1);
    chk("error_sticky", 32'(error), 32'd1);
    words = '{32'h87654321};
    send_frame(32'h0000_3008, 1'b0);
    wait_done(1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
